psum_collector: RTL

Output-side companion to the systolic array. It captures the column-skewed partial sums the array emits, one per column when that column's enable is high. Across multiple K-tiles it overwrites on the first tile and accumulates on later tiles into a row-major buffer. When every column has finished, it drains the de-skewed result rows over a valid/ready stream to the output buffer or writeback path.

---
 rtl/psum_collector.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/psum_collector.sv
// Partial-sum collector: captures column-skewed array outputs, accumulates K-tiles, drains rows.
// Optional build macro PSUM_COLLECT_SAT_EN selects signed saturating accumulation (default wraps).
module psum_collector #(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
  localparam int RW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [RW-1:0]         num_rows,
  input  logic [7:0]            num_tiles,
  input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
  input  logic [SYS_COL-1:0]    en_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data [0:SYS_COL-1],
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rows_q;
  logic [7:0]            tiles_q;
  logic [RW-1:0]         rows_m1;
  logic [RW-1:0]         row_cnt  [SYS_COL];
  logic [7:0]            tile_cnt [SYS_COL];
  logic [PSUM_WIDTH-1:0] psum_buf [DEPTH][SYS_COL];
  logic [PSUM_WIDTH-1:0] acc_sum  [SYS_COL];
  logic [RW-1:0]         rd_ptr;
  logic                  done_q, err_q;
  logic                  start_ok, start_bad, fire, last_xfer;
  logic [SYS_COL-1:0]    col_acc, col_fin, col_drop;

  function automatic logic [PSUM_WIDTH-1:0] acc_add(input logic [PSUM_WIDTH-1:0] a,
                                                    input logic [PSUM_WIDTH-1:0] b);
    logic [PSUM_WIDTH-1:0] s;
    s = a + b;
`ifdef PSUM_COLLECT_SAT_EN
    // Overflow only when both operands share a sign that the sum does not.
    if ((a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1]))
      s = a[PSUM_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  assign rows_m1   = rows_q - RW'(1);
  assign start_bad = start && (state_q == IDLE) &&
                     ((num_rows == '0) || (num_rows > RW'(DEPTH)) || (num_tiles == '0));
  assign start_ok  = start && (state_q == IDLE) && !start_bad;

  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (rd_ptr == rows_m1);
  assign fire      = out_valid && out_ready;
  assign last_xfer = fire && out_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

  // A column counts as finished this cycle if its final write is landing now,
  // so DRAIN starts the cycle right after the last capture.
  always_comb begin
    col_acc  = '0;
    col_fin  = '0;
    col_drop = '0;
    for (int c = 0; c < SYS_COL; c++) begin
      col_acc[c]  = (state_q == COLLECT) && en_in[c] && (tile_cnt[c] != tiles_q);
      col_drop[c] = en_in[c] && ((state_q != COLLECT) || (tile_cnt[c] == tiles_q));
      col_fin[c]  = (tile_cnt[c] == tiles_q) ||
                    (col_acc[c] && (row_cnt[c] == rows_m1) && (tile_cnt[c] == tiles_q - 8'd1));
      acc_sum[c]  = acc_add(psum_buf[row_cnt[c][AW-1:0]][c], psum_in[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < SYS_COL; c++) out_data[c] = psum_buf[rd_ptr[AW-1:0]][c];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = COLLECT;
      COLLECT: if (&col_fin) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q  <= '0;
      tiles_q <= '0;
      rd_ptr  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < SYS_COL; c++) begin
        row_cnt[c]  <= '0;
        tile_cnt[c] <= '0;
      end
    end else begin
      done_q <= start_bad || last_xfer;
      if (start_ok)                    err_q <= 1'b0;
      else if (start_bad || |col_drop) err_q <= 1'b1;

      if (start_ok) begin
        rows_q  <= num_rows;
        tiles_q <= num_tiles;
        rd_ptr  <= '0;
        for (int c = 0; c < SYS_COL; c++) begin
          row_cnt[c]  <= '0;
          tile_cnt[c] <= '0;
        end
      end else begin
        if (fire) rd_ptr <= last_xfer ? '0 : rd_ptr + RW'(1);
        for (int c = 0; c < SYS_COL; c++) begin
          if (col_acc[c]) begin
            if (row_cnt[c] == rows_m1) begin
              row_cnt[c]  <= '0;
              tile_cnt[c] <= tile_cnt[c] + 8'd1;
            end else begin
              row_cnt[c] <= row_cnt[c] + RW'(1);
            end
          end
        end
      end
    end
  end

  // Tile 0 overwrites, so the buffer never needs clearing between jobs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < DEPTH; d++)
        for (int c = 0; c < SYS_COL; c++) psum_buf[d][c] <= '0;
    end else begin
      for (int c = 0; c < SYS_COL; c++) begin
        if (col_acc[c])
          psum_buf[row_cnt[c][AW-1:0]][c] <= (tile_cnt[c] == 8'd0) ? psum_in[c] : acc_sum[c];
      end
    end
  end

endmodule
